tile_span_shader: RTL and testbench

Parametrised per-tile fragment writer and successor to the fixed 8×8/4-lane tile rasteriser. On `start` it clips a primitive bounding box to the current screen tile. It then walks the clipped rectangle `LANES` pixels per cycle, reads the tile z-buffer, depth-tests each lane and emits masked colour/depth writes into one half of the double-buffered colour tile. It sits between primitive setup and the tile buffers, and signals completion with a one-cycle `done`.

---
 rtl/tile_pkg.sv | 30 +++
 rtl/tile_span_shader_if.sv | 58 +++++
 rtl/tile_clip_rect.sv | 75 +++++++
 rtl/tile_span_shader.sv | 146 ++++++++++++++
 tb/tb_tile_span_shader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared types, default geometry and the lane-validity helper for the tile span shader.
package tile_pkg;

    localparam int TILE_DIM_DEF = 8;
    localparam int LANES_DEF    = 4;
    localparam int COLOR_W_DEF  = 16;
    localparam int Z_W_DEF      = 16;
    localparam int COORD_W_DEF  = 10;
    localparam int MAX_LANES    = 32;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DRAIN,
        DONE
    } state_t;

    // Bit i set when column col+i lies left of the exclusive clip edge x1.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned col, input int unsigned x1);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (col + i < x1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tile_span_shader_if.sv
// Request, z-buffer read and fragment write bundle between primitive setup, the shader and the tile buffers.
interface tile_span_shader_if
    import tile_pkg::*;
#(
    parameter int TILE_DIM = TILE_DIM_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int Z_W      = Z_W_DEF,
    parameter int COORD_W  = COORD_W_DEF
);
    localparam int RW = $clog2(TILE_DIM);

    logic                 start;
    logic [COORD_W-1:0]   tile_x;
    logic [COORD_W-1:0]   tile_y;
    logic [COORD_W-1:0]   box_x;
    logic [COORD_W-1:0]   box_y;
    logic [COORD_W-1:0]   box_w;
    logic [COORD_W-1:0]   box_h;
    logic [COLOR_W-1:0]   frag_color;
    logic [Z_W-1:0]       frag_z;
    logic                 tile_sel;
    logic                 z_test_en;

    logic                 zrd_en;
    logic [RW-1:0]        zrd_row;
    logic [RW-1:0]        zrd_col;
    logic [LANES*Z_W-1:0] zrd_data;

    logic                 wr_en;
    logic [LANES-1:0]     wr_mask;
    logic [RW-1:0]        wr_row;
    logic [RW-1:0]        wr_col;
    logic [COLOR_W-1:0]   wr_color;
    logic [Z_W-1:0]       wr_z;
    logic                 wr_buf;
    logic                 wr_zen;

    logic                 busy;
    logic                 done;

    modport master (
        output start, tile_x, tile_y, box_x, box_y, box_w, box_h,
        output frag_color, frag_z, tile_sel, z_test_en, zrd_data,
        input  zrd_en, zrd_row, zrd_col,
        input  wr_en, wr_mask, wr_row, wr_col, wr_color, wr_z, wr_buf, wr_zen,
        input  busy, done
    );

    modport slave (
        input  start, tile_x, tile_y, box_x, box_y, box_w, box_h,
        input  frag_color, frag_z, tile_sel, z_test_en, zrd_data,
        output zrd_en, zrd_row, zrd_col,
        output wr_en, wr_mask, wr_row, wr_col, wr_color, wr_z, wr_buf, wr_zen,
        output busy, done
    );

endinterface

// File: rtl/tile_clip_rect.sv
// Clips a screen-space bounding box to one tile and yields tile-local bounds.
// Combinational bounds feed the walk start; registered copies steer the walk.
module tile_clip_rect
    import tile_pkg::*;
#(
    parameter int TILE_DIM = TILE_DIM_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    localparam int RW      = $clog2(TILE_DIM)
) (
    input  logic               BOARD_CLK,
    input  logic               reset,
    input  logic               load,
    input  logic [COORD_W-1:0] tile_x,
    input  logic [COORD_W-1:0] tile_y,
    input  logic [COORD_W-1:0] box_x,
    input  logic [COORD_W-1:0] box_y,
    input  logic [COORD_W-1:0] box_w,
    input  logic [COORD_W-1:0] box_h,
    output logic               empty,
    output logic [RW-1:0]      x0_now,
    output logic [RW-1:0]      y0_now,
    output logic [RW-1:0]      x0_reg,
    output logic [RW:0]        x1_reg,
    output logic [RW:0]        y1_reg
);
    localparam int CW1 = COORD_W + 1;
    localparam int LW  = RW + 1;

    // Axis 0 is x, axis 1 is y; one extra bit keeps box end and tile end from wrapping.
    logic [CW1-1:0] t_lo [2];
    logic [CW1-1:0] t_hi [2];
    logic [CW1-1:0] b_lo [2];
    logic [CW1-1:0] b_hi [2];
    logic [CW1-1:0] c_lo [2];
    logic [CW1-1:0] c_hi [2];
    logic [RW-1:0]  loc_lo [2];
    logic [LW-1:0]  loc_hi [2];
    logic [1:0]     axis_empty;

    assign t_lo[0] = {1'b0, tile_x};
    assign t_lo[1] = {1'b0, tile_y};
    assign b_lo[0] = {1'b0, box_x};
    assign b_lo[1] = {1'b0, box_y};
    assign b_hi[0] = {1'b0, box_x} + {1'b0, box_w};
    assign b_hi[1] = {1'b0, box_y} + {1'b0, box_h};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            assign t_hi[gi]       = t_lo[gi] + CW1'(TILE_DIM);
            assign c_lo[gi]       = (b_lo[gi] > t_lo[gi]) ? b_lo[gi] : t_lo[gi];
            assign c_hi[gi]       = (b_hi[gi] < t_hi[gi]) ? b_hi[gi] : t_hi[gi];
            assign axis_empty[gi] = (c_lo[gi] >= c_hi[gi]);
            // Truncation is safe whenever the clip is non-empty: lo < TILE_DIM, hi <= TILE_DIM.
            assign loc_lo[gi]     = RW'(c_lo[gi] - t_lo[gi]);
            assign loc_hi[gi]     = LW'(c_hi[gi] - t_lo[gi]);
        end
    endgenerate

    assign empty  = |axis_empty;
    assign x0_now = loc_lo[0];
    assign y0_now = loc_lo[1];

    always_ff @(posedge BOARD_CLK) begin
        if (reset) begin
            x0_reg <= '0;
            x1_reg <= '0;
            y1_reg <= '0;
        end else if (load) begin
            x0_reg <= loc_lo[0];
            x1_reg <= loc_hi[0];
            y1_reg <= loc_hi[1];
        end
    end

endmodule

// File: rtl/tile_span_shader.sv
// Per-tile fragment writer: clips a box to the tile, walks it LANES pixels per cycle,
// depth-tests against the z-buffer read and emits masked colour/depth writes.
module tile_span_shader
    import tile_pkg::*;
#(
    parameter int TILE_DIM = TILE_DIM_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int Z_W      = Z_W_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic              BOARD_CLK,
    input  logic              reset,
    tile_span_shader_if.slave bus
);
    localparam int RW = $clog2(TILE_DIM);
    localparam int LW = RW + 1;

    state_t             state_reg, state_next;
    logic               accept, walking, busy, done;
    logic               empty_now;
    logic [RW-1:0]      x0_now, y0_now, x0_reg;
    logic [LW-1:0]      x1_reg, y1_reg;
    logic [RW-1:0]      row_reg, col_reg;
    logic [LW-1:0]      col_step;
    logic               row_wrap, last_group;
    logic [LANES-1:0]   lane_valid, lane_pass;

    logic [COLOR_W-1:0] color_reg;
    logic [Z_W-1:0]     z_reg;
    logic               buf_reg, zen_reg;

    logic               wr_en_reg;
    logic [RW-1:0]      wr_row_reg, wr_col_reg;
    logic [LANES-1:0]   wr_valid_reg;

    tile_clip_rect #(
        .TILE_DIM (TILE_DIM),
        .COORD_W  (COORD_W)
    ) u_clip (
        .BOARD_CLK (BOARD_CLK),
        .reset     (reset),
        .load      (accept),
        .tile_x    (bus.tile_x),
        .tile_y    (bus.tile_y),
        .box_x     (bus.box_x),
        .box_y     (bus.box_y),
        .box_w     (bus.box_w),
        .box_h     (bus.box_h),
        .empty     (empty_now),
        .x0_now    (x0_now),
        .y0_now    (y0_now),
        .x0_reg    (x0_reg),
        .x1_reg    (x1_reg),
        .y1_reg    (y1_reg)
    );

    assign col_step   = {1'b0, col_reg} + LW'(LANES);
    assign row_wrap   = (col_step >= x1_reg);
    assign last_group = row_wrap && (({1'b0, row_reg} + LW'(1)) == y1_reg);
    assign lane_valid = LANES'(lane_mask(32'(col_reg), 32'(x1_reg)));

    always_ff @(posedge BOARD_CLK) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = empty_now ? DONE : WALK;
            WALK:    if (last_group) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_reg == IDLE) && bus.start;
        walking = (state_reg == WALK);
        busy    = (state_reg != IDLE);
        done    = (state_reg == DONE);
    end

    // Walk position plus the write-stage pipeline register.
    always_ff @(posedge BOARD_CLK) begin
        if (reset) begin
            row_reg      <= '0;
            col_reg      <= '0;
            color_reg    <= '0;
            z_reg        <= '0;
            buf_reg      <= 1'b0;
            zen_reg      <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_row_reg   <= '0;
            wr_col_reg   <= '0;
            wr_valid_reg <= '0;
        end else begin
            if (accept) begin
                row_reg   <= y0_now;
                col_reg   <= x0_now;
                color_reg <= bus.frag_color;
                z_reg     <= bus.frag_z;
                buf_reg   <= bus.tile_sel;
                zen_reg   <= bus.z_test_en;
            end else if (walking && !last_group) begin
                if (row_wrap) begin
                    col_reg <= x0_reg;
                    row_reg <= row_reg + RW'(1);
                end else begin
                    col_reg <= RW'(col_step);
                end
            end
            wr_en_reg    <= walking;
            wr_row_reg   <= row_reg;
            wr_col_reg   <= col_reg;
            wr_valid_reg <= walking ? lane_valid : '0;
        end
    end

    // Depth compare uses read data arriving in the write cycle.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_pass[gi] = !zen_reg || (z_reg < bus.zrd_data[gi*Z_W +: Z_W]);
        end
    endgenerate

    assign bus.zrd_en   = walking;
    assign bus.zrd_row  = row_reg;
    assign bus.zrd_col  = col_reg;
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_mask  = wr_valid_reg & lane_pass;
    assign bus.wr_row   = wr_row_reg;
    assign bus.wr_col   = wr_col_reg;
    assign bus.wr_color = color_reg;
    assign bus.wr_z     = z_reg;
    assign bus.wr_buf   = buf_reg;
    assign bus.wr_zen   = zen_reg;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_tile_span_shader.sv
// Scoreboard bench for tile_span_shader: a bench-side clip/walk model queues expected
// writes per job and a monitor compares every wr_en cycle against the queue.
module tb_tile_span_shader;
    import tile_pkg::*;

    typedef struct {
        int          row;
        int          col;
        logic [3:0]  mask;
        logic [15:0] color;
        logic [15:0] z;
        logic        sel;
        logic        zen;
    } wr_item_t;

    logic        board_clk = 1'b0;
    logic        rst;
    wr_item_t    sb_q [$];
    int          checks_cnt = 0;
    int          errors_cnt = 0;
    logic [15:0] zmem [8][8];
    logic [63:0] zrd_next;

    always #5 board_clk = ~board_clk;

    tile_span_shader_if bus ();

    tile_span_shader u_dut (
        .BOARD_CLK (board_clk),
        .reset     (rst),
        .bus       (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({bus.zrd_en, bus.zrd_row, bus.zrd_col, bus.wr_en, bus.wr_mask,
                    bus.wr_row, bus.wr_col, bus.wr_color, bus.wr_z, bus.wr_buf,
                    bus.wr_zen, bus.busy, bus.done});
    endfunction

    // Z-buffer model: four lanes from the addressed row, valid the cycle after zrd_en.
    always_comb begin
        zrd_next = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(bus.zrd_col) + i < 8) begin
                zrd_next[i*16 +: 16] = zmem[bus.zrd_row][int'(bus.zrd_col) + i];
            end else begin
                zrd_next[i*16 +: 16] = 16'hFFFF;
            end
        end
    end

    always @(posedge board_clk) begin
        if (bus.zrd_en) begin
            bus.zrd_data <= zrd_next;
        end
    end

    always @(negedge board_clk) begin
        if (bus.wr_en) begin
            if (sb_q.size() == 0) begin
                check_eq("wr_unexpected", 64'd1, 64'd0);
            end else begin
                wr_item_t e;
                e = sb_q.pop_front();
                check_eq("wr_row", 64'(bus.wr_row), 64'(e.row));
                check_eq("wr_col", 64'(bus.wr_col), 64'(e.col));
                check_eq("wr_mask", 64'(bus.wr_mask), 64'(e.mask));
                check_eq("wr_color", 64'(bus.wr_color), 64'(e.color));
                check_eq("wr_z", 64'(bus.wr_z), 64'(e.z));
                check_eq("wr_buf", 64'(bus.wr_buf), 64'(e.sel));
                check_eq("wr_zen", 64'(bus.wr_zen), 64'(e.zen));
            end
        end
    end

    task automatic build_expect(input int tx, input int ty, input int bx, input int by,
                                input int bw, input int bh, input logic zen,
                                input logic [15:0] fz, input logic [15:0] color,
                                input logic sel, output int g);
        int x0, x1, y0, y1;
        wr_item_t it;
        g  = 0;
        x0 = (bx > tx) ? bx : tx;
        x1 = (bx + bw < tx + 8) ? bx + bw : tx + 8;
        y0 = (by > ty) ? by : ty;
        y1 = (by + bh < ty + 8) ? by + bh : ty + 8;
        if (x0 < x1 && y0 < y1) begin
            for (int r = y0 - ty; r < y1 - ty; r++) begin
                for (int c = x0 - tx; c < x1 - tx; c += 4) begin
                    it.row = r; it.col = c; it.mask = '0;
                    it.color = color; it.z = fz; it.sel = sel; it.zen = zen;
                    for (int i = 0; i < 4; i++) begin
                        if ((c + i < x1 - tx) && (!zen || fz < zmem[r][c + i])) it.mask[i] = 1'b1;
                    end
                    sb_q.push_back(it);
                    g++;
                end
            end
        end
    endtask

    task automatic drive_req(input int tx, input int ty, input int bx, input int by,
                             input int bw, input int bh, input logic zen,
                             input logic [15:0] fz, input logic [15:0] color, input logic sel);
        bus.tile_x = 10'(tx); bus.tile_y = 10'(ty);
        bus.box_x = 10'(bx); bus.box_y = 10'(by); bus.box_w = 10'(bw); bus.box_h = 10'(bh);
        bus.z_test_en = zen; bus.frag_z = fz; bus.frag_color = color; bus.tile_sel = sel;
    endtask

    task automatic scramble_req();
        bus.box_x = 10'($urandom_range(0, 60)); bus.box_y = 10'($urandom_range(0, 60));
        bus.box_w = 10'($urandom_range(0, 20)); bus.box_h = 10'($urandom_range(0, 20));
        bus.tile_x = 10'($urandom_range(0, 60)); bus.frag_z = 16'($urandom);
        bus.frag_color = 16'($urandom); bus.z_test_en = ~bus.z_test_en; bus.tile_sel = ~bus.tile_sel;
    endtask

    task automatic run_job(input string name, input int tx, input int ty, input int bx, input int by,
                           input int bw, input int bh, input logic zen, input logic [15:0] fz,
                           input logic [15:0] color, input logic sel, input bit repulse);
        int g, cyc, done_cyc, zrd_cnt, wr_cnt, busy_cnt, first_zrd, extra_done;
        @(negedge board_clk);
        drive_req(tx, ty, bx, by, bw, bh, zen, fz, color, sel);
        build_expect(tx, ty, bx, by, bw, bh, zen, fz, color, sel, g);
        bus.start = 1'b1;
        @(posedge board_clk);
        #1;
        bus.start = 1'b0;
        scramble_req();
        cyc = 0; done_cyc = 0; zrd_cnt = 0; wr_cnt = 0; busy_cnt = 0; first_zrd = 0;
        while (done_cyc == 0 && cyc < 100) begin
            @(negedge board_clk);
            cyc++;
            if (bus.zrd_en) begin
                zrd_cnt++;
                if (first_zrd == 0) first_zrd = cyc;
            end
            if (bus.wr_en) wr_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cyc = cyc;
            if (repulse && cyc == 1) bus.start = 1'b1;
            if (repulse && cyc == 3) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check_eq({name, "_done_cyc"}, 64'(done_cyc), 64'((g == 0) ? 1 : g + 2));
        check_eq({name, "_zrd_cnt"}, 64'(zrd_cnt), 64'(g));
        check_eq({name, "_wr_cnt"}, 64'(wr_cnt), 64'(g));
        check_eq({name, "_busy_cnt"}, 64'(busy_cnt), 64'((g == 0) ? 1 : g + 2));
        if (g > 0) check_eq({name, "_first_zrd"}, 64'(first_zrd), 64'd1);
        extra_done = 0;
        repeat (4) begin
            @(negedge board_clk);
            if (bus.done) extra_done++;
        end
        check_eq({name, "_extra_done"}, 64'(extra_done), 64'd0);
        check_eq({name, "_idle"}, 64'(bus.busy), 64'd0);
        check_eq({name, "_sb_left"}, 64'(sb_q.size()), 64'd0);
        $display("job %s groups=%0d done_cyc=%0d writes=%0d", name, g, done_cyc, wr_cnt);
    endtask

    initial begin
        int g, late_done;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.zrd_data = '0;
        drive_req(0, 0, 0, 0, 0, 0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) zmem[r][c] = 16'($urandom);
        repeat (3) @(posedge board_clk);
        @(negedge board_clk);
        check_eq("reset_outs", outs_vec(), 64'd0);
        rst = 1'b0;

        run_job("t1_full",  8, 8, 8, 8, 8, 8, 1'b0, 16'h0100, 16'hA5A5, 1'b1, 1'b0);
        run_job("t2_small", 8, 8, 10, 9, 3, 2, 1'b0, 16'h0200, 16'h1234, 1'b0, 1'b0);
        run_job("t3_empty", 16, 0, 0, 0, 4, 4, 1'b0, 16'h0300, 16'h5678, 1'b0, 1'b0);
        run_job("t_zero_w", 0, 0, 2, 2, 0, 3, 1'b0, 16'h0000, 16'h0F0F, 1'b0, 1'b0);
        zmem[0][0] = 16'd50; zmem[0][1] = 16'd100; zmem[0][2] = 16'd150; zmem[0][3] = 16'd200;
        run_job("t4_ztest", 0, 0, 0, 0, 4, 1, 1'b1, 16'd100, 16'hBEEF, 1'b1, 1'b0);

        // Reset in the middle of a walk: two writes seen, the rest dropped, no done.
        @(negedge board_clk);
        drive_req(0, 0, 0, 0, 8, 8, 1'b0, 16'h0400, 16'hC0DE, 1'b0);
        build_expect(0, 0, 0, 0, 8, 8, 1'b0, 16'h0400, 16'hC0DE, 1'b0, g);
        bus.start = 1'b1;
        @(posedge board_clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge board_clk);
        rst = 1'b1;
        @(posedge board_clk);
        #1;
        check_eq("t5_pending", 64'(sb_q.size()), 64'(g - 2));
        sb_q.delete();
        @(negedge board_clk);
        check_eq("t5_rst_outs", outs_vec(), 64'd0);
        rst = 1'b0;
        late_done = 0;
        repeat (6) begin
            @(negedge board_clk);
            if (bus.done) late_done++;
        end
        check_eq("t5_no_done", 64'(late_done), 64'd0);
        $display("job t5_reset groups=%0d aborted after 3", g);
        run_job("t5_after", 8, 0, 6, 2, 9, 3, 1'b0, 16'h0500, 16'h7777, 1'b1, 1'b0);

        run_job("t6_repulse", 0, 0, 5, 0, 10, 1, 1'b0, 16'h0600, 16'h3C3C, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            int tx, ty;
            tx = 8 * $urandom_range(0, 3);
            ty = 8 * $urandom_range(0, 3);
            run_job($sformatf("rnd%0d", k), tx, ty,
                    $urandom_range(0, 32), $urandom_range(0, 32),
                    $urandom_range(0, 12), $urandom_range(0, 12),
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
